// File: rtl/up2_ctrl.sv
// up2 sequencing controller: fetch/exec FSM driving the up2_alu datapath.
// Define UP2_CTRL_STEP_EN to add the i_step port and single-step STEP state.
module up2_ctrl (
    input  logic       clk,
    input  logic       nRst,
    input  logic       i_start,
`ifdef UP2_CTRL_STEP_EN
    input  logic       i_step,
`endif
    input  logic [7:0] i_instr,
    input  logic [3:0] i_r0,
    input  logic [3:0] i_r1,
    input  logic [3:0] i_r2,
    input  logic       i_zero_flag,
    output logic [3:0] o_pc,
    output logic       o_r_write,
    output logic [3:0] o_r0,
    output logic [3:0] o_r1,
    output logic [3:0] o_r2,
    output logic [3:0] o_mux_sel,
    output logic [3:0] o_alu_op,
    output logic       o_busy,
    output logic       o_halted
);

`ifdef UP2_CTRL_STEP_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        STEP  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;
`endif

    state_t     state;
    state_t     state_n;
    logic [3:0] pc;
    logic [3:0] pc_n;
    logic [7:0] ir;
    logic [7:0] ir_n;
    logic       z;
    logic       z_n;
    logic [1:0] opc;

    assign opc  = ir[7:6];
    assign o_pc = pc;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state <= IDLE;
            pc    <= 4'd0;
            ir    <= 8'd0;
            z     <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            z     <= z_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        z_n       = z;
        o_r_write = 1'b0;
        o_r0      = i_r0;
        o_r1      = i_r1;
        o_r2      = i_r2;
        o_mux_sel = 4'b0011;
        o_alu_op  = 4'd0;
        o_busy    = 1'b0;
        o_halted  = 1'b0;
        unique case (state)
            IDLE, HALT: begin
                o_halted = (state == HALT) && nRst;
                if (i_start) begin
                    pc_n    = 4'd0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                o_busy  = nRst;
                ir_n    = i_instr;
                state_n = EXEC;
            end
            EXEC: begin
                o_busy  = nRst;
                pc_n    = pc + 4'd1;
`ifdef UP2_CTRL_STEP_EN
                state_n = STEP;
`else
                state_n = FETCH;
`endif
                unique case (opc)
                    2'b00: begin
                        // Gated by nRst so a reset edge never commits an ALU write.
                        if (nRst) begin
                            o_mux_sel = ir[5:2];
                            o_alu_op  = {3'b000, ir[1]};
                        end
                        z_n = i_zero_flag;
                    end
                    2'b01: begin
                        if (nRst) begin
                            o_r_write = 1'b1;
                            if (ir[5:4] == 2'd0) o_r0 = ir[3:0];
                            if (ir[5:4] == 2'd1) o_r1 = ir[3:0];
                            if (ir[5:4] == 2'd2) o_r2 = ir[3:0];
                        end
                    end
                    2'b10: begin
                        if (z) pc_n = ir[3:0];
                    end
                    default: begin
                        if (ir[5]) begin
                            pc_n    = pc;
                            state_n = HALT;
                        end else begin
                            pc_n = ir[3:0];
                        end
                    end
                endcase
            end
`ifdef UP2_CTRL_STEP_EN
            STEP: begin
                o_busy = nRst;
                if (i_step) state_n = FETCH;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
